traffic_phase_ctrl: RTL and testbench

//  Phase sequencer for the two-road traffic light: NS green/yellow -> all-red -> EW green/yellow -> all-red.

---
 rtl/traffic_phase_ctrl_pkg.sv | 56 +++++
 rtl/traffic_phase_ctrl_timer.sv | 37 +++
 rtl/traffic_phase_ctrl.sv | 157 +++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_phase_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : traffic_phase_ctrl_pkg
// Purpose : Shared phase encodings, lamp codes and decode helpers for the
//           two-road traffic phase sequencer.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package traffic_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    ALLRED_NS = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_EW = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    NIGHT     = 3'd6
  } phase_e;

  // Lamp codes are {R,Y,G}
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  // Day-cycle successor; NIGHT is left through ALLRED_NS by the FSM itself.
  function automatic phase_e next_phase(input phase_e s);
    phase_e n;
    case (s)
      ALLRED_NS: n = NS_GREEN;
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALLRED_EW;
      ALLRED_EW: n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      default:   n = ALLRED_NS;
    endcase
    return n;
  endfunction

  // Returns {ns_lights, ew_lights}
  function automatic logic [5:0] lamps_for(input phase_e s, input logic flash);
    logic [5:0] l;
    case (s)
      NS_GREEN:  l = {L_GRN, L_RED};
      NS_YELLOW: l = {L_YEL, L_RED};
      EW_GREEN:  l = {L_RED, L_GRN};
      EW_YELLOW: l = {L_RED, L_YEL};
      NIGHT:     l = flash ? {L_YEL, L_YEL} : {L_OFF, L_OFF};
      default:   l = {L_RED, L_RED};
    endcase
    return l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module  : traffic_phase_ctrl_timer
// Purpose : 7-bit phase down-counter. load has priority over dec; dec at
//           zero holds at zero so the count can never wrap.
// Ports   : clk, rst_n      clock / async active-low reset
//           load, load_val  synchronous load of a new count
//           dec             decrement by one
//           count           current count (seconds left minus 1)
//           zero            count == 0
// Rev     : 1.0  initial release
// ============================================================================
module traffic_phase_ctrl_timer #(
  parameter logic [6:0] RESET_VAL = 7'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       dec,
  output logic [6:0] count,
  output logic       zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= RESET_VAL;
    else if (load)
      count <= load_val;
    else if (dec && (count != 7'd0))
      count <= count - 7'd1;
  end

  assign zero = (count == 7'd0);

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : traffic_phase_ctrl
// Purpose : Two-road traffic phase sequencer with pedestrian walk service and
//           flashing-yellow night mode. Advances only on en & sec_tick.
// Ports   : clk, rst_n      clock / async active-low reset
//           en              run enable (0 freezes everything but ped latch)
//           sec_tick        one-clk pulse per second
//           ped_req         pedestrian request, latched
//           night_mode      request flashing-yellow mode
//           ns_lights       NS lamps {R,Y,G}
//           ew_lights       EW lamps {R,Y,G}
//           ped_walk        walk lamp
//           phase           current phase encoding
//           remaining       seconds left in phase minus 1
//           phase_done      one-clk pulse after each phase transition
// Rev     : 1.0  initial release
// ============================================================================
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int unsigned pGREEN_NS = 20,
  parameter int unsigned pGREEN_EW = 15,
  parameter int unsigned pYELLOW   = 3,
  parameter int unsigned pALL_RED  = 1,
  parameter int unsigned pPED_WALK = 8,
  parameter int unsigned pPED_MIN  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sec_tick,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic       ped_walk,
  output logic [2:0] phase,
  output logic [6:0] remaining,
  output logic       phase_done
);

  localparam logic [6:0] GREEN_NS_M1 = 7'(pGREEN_NS - 1);
  localparam logic [6:0] GREEN_EW_M1 = 7'(pGREEN_EW - 1);
  localparam logic [6:0] YELLOW_M1   = 7'(pYELLOW - 1);
  localparam logic [6:0] ALL_RED_M1  = 7'(pALL_RED - 1);
  localparam logic [6:0] PED_WALK_M1 = 7'(pPED_WALK - 1);
  localparam logic [6:0] PED_MIN     = 7'(pPED_MIN);

  function automatic logic [6:0] dur_m1(input phase_e s);
    logic [6:0] d;
    case (s)
      NS_GREEN:             d = GREEN_NS_M1;
      EW_GREEN:             d = GREEN_EW_M1;
      NS_YELLOW, EW_YELLOW: d = YELLOW_M1;
      ALLRED_NS, ALLRED_EW: d = ALL_RED_M1;
      default:              d = 7'd0;
    endcase
    return d;
  endfunction

  phase_e     state, next_state, succ;
  logic       flash, next_flash;
  logic       ped_pending, next_pending;
  logic       next_walk, next_done;
  logic       tick, pend, is_green;
  logic       load, dec, zero;
  logic [6:0] load_val, count;

  traffic_phase_ctrl_timer #(
    .RESET_VAL (ALL_RED_M1)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .count    (count),
    .zero     (zero)
  );

  assign tick     = en & sec_tick;
  assign pend     = ped_pending | ped_req;
  assign is_green = (state == NS_GREEN) || (state == EW_GREEN);
  assign succ     = next_phase(state);

  always_comb begin
    next_state   = state;
    next_flash   = flash;
    next_walk    = ped_walk;
    next_pending = ped_pending | ped_req;   // latching runs even when frozen
    next_done    = 1'b0;
    load         = 1'b0;
    load_val     = 7'd0;
    dec          = 1'b0;
    if (tick) begin
      if (state == NIGHT) begin
        if (!night_mode) begin
          next_state = ALLRED_NS;
          load       = 1'b1;
          load_val   = ALL_RED_M1;
          next_flash = 1'b0;
          next_done  = 1'b1;
        end else begin
          next_flash = ~flash;
        end
      end else if (zero) begin
        next_done = 1'b1;
        next_walk = 1'b0;
        load      = 1'b1;
        if (night_mode) begin
          next_state = NIGHT;
          load_val   = 7'd0;
        end else begin
          next_state = succ;
          load_val   = dur_m1(succ);
          // A pending request turns the coming all-red into a walk phase
          // and is consumed by it, including a same-cycle request.
          if (((succ == ALLRED_NS) || (succ == ALLRED_EW)) && pend) begin
            load_val     = PED_WALK_M1;
            next_walk    = 1'b1;
            next_pending = 1'b0;
          end
        end
      end else if (is_green && pend && (count > PED_MIN)) begin
        load     = 1'b1;
        load_val = PED_MIN;
      end else begin
        dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ALLRED_NS;
      flash       <= 1'b0;
      ped_pending <= 1'b0;
      ped_walk    <= 1'b0;
      phase_done  <= 1'b0;
      ns_lights   <= L_RED;
      ew_lights   <= L_RED;
    end else begin
      state                  <= next_state;
      flash                  <= next_flash;
      ped_pending            <= next_pending;
      ped_walk               <= next_walk;
      phase_done             <= next_done;
      {ns_lights, ew_lights} <= lamps_for(next_state, next_flash);
    end
  end

  assign phase     = state;
  assign remaining = count;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_traffic_phase_ctrl
// Purpose : Directed scoreboard bench for traffic_phase_ctrl. Stimulus pushes
//           the hand-computed post-tick output word; a monitor pops and
//           compares after every cycle where sec_tick is presented.
// Rev     : 1.0  initial release
// ============================================================================
module tb_traffic_phase_ctrl;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       sec_tick = 1'b0;
  logic       ped_req = 1'b0;
  logic       night_mode = 1'b0;
  logic [2:0] ns_lights, ew_lights, phase;
  logic       ped_walk, phase_done;
  logic [6:0] remaining;

  int tests = 0;
  int fails = 0;
  int tick_id = 0;

  // {phase, remaining, ns, ew, walk, done}
  logic [17:0] exp_q[$];

  traffic_phase_ctrl #(
    .pGREEN_NS (5),
    .pGREEN_EW (4),
    .pYELLOW   (2),
    .pALL_RED  (1),
    .pPED_WALK (3),
    .pPED_MIN  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sec_tick   (sec_tick),
    .ped_req    (ped_req),
    .night_mode (night_mode),
    .ns_lights  (ns_lights),
    .ew_lights  (ew_lights),
    .ped_walk   (ped_walk),
    .phase      (phase),
    .remaining  (remaining),
    .phase_done (phase_done)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] actual();
    return {phase, remaining, ns_lights, ew_lights, ped_walk, phase_done};
  endfunction

  // Monitor: every presented tick must have an expected word waiting.
  always @(posedge clk) begin
    if (rst_n && sec_tick) begin
      logic [17:0] e, a;
      #1;
      a = actual();
      tick_id++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL tick%0d unexpected: got %h, no expected entry", tick_id, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL tick%0d got ph=%0d rem=%0d ns=%b ew=%b walk=%b done=%b, need ph=%0d rem=%0d ns=%b ew=%b walk=%b done=%b",
                   tick_id, a[17:15], a[14:8], a[7:5], a[4:2], a[1], a[0],
                   e[17:15], e[14:8], e[7:5], e[4:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic tk(input logic [2:0] ph, input logic [6:0] rem,
                    input logic [2:0] ns, input logic [2:0] ew,
                    input logic w, input logic d);
    exp_q.push_back({ph, rem, ns, ew, w, d});
    sec_tick = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input logic req);
    sec_tick = 1'b0;
    ped_req  = req;
    @(negedge clk);
    ped_req  = 1'b0;
  endtask

  task automatic chk_reset(input string name);
    tests++;
    if (actual() !== {3'd0, 7'd0, R, R, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL %s got %h need %h", name, actual(), {3'd0, 7'd0, R, R, 1'b0, 1'b0});
    end
  endtask

  task automatic green_ns_full();
    tk(1, 4, G, R, 0, 1); tk(1, 3, G, R, 0, 0); tk(1, 2, G, R, 0, 0);
    tk(1, 1, G, R, 0, 0); tk(1, 0, G, R, 0, 0);
  endtask

  task automatic ew_green_to_allred_ns();
    tk(4, 3, R, G, 0, 1); tk(4, 2, R, G, 0, 0); tk(4, 1, R, G, 0, 0);
    tk(4, 0, R, G, 0, 0); tk(5, 1, R, Y, 0, 1); tk(5, 0, R, Y, 0, 0);
    tk(0, 0, R, R, 0, 1);
  endtask

  task automatic full_cycle();
    green_ns_full();
    tk(2, 1, Y, R, 0, 1); tk(2, 0, Y, R, 0, 0);
    tk(3, 0, R, R, 0, 1);
    ew_green_to_allred_ns();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk); @(negedge clk);
    chk_reset("reset_values");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: free-running cycle with sec_tick held high
    full_cycle();

    // 2: request latched between ticks in NS_GREEN at remaining=4
    tk(1, 4, G, R, 0, 1);
    idle(1'b1);
    tk(1, 1, G, R, 0, 0); tk(1, 0, G, R, 0, 0);
    tk(2, 1, Y, R, 0, 1); tk(2, 0, Y, R, 0, 0);
    tk(3, 2, R, R, 1, 1); tk(3, 1, R, R, 1, 0); tk(3, 0, R, R, 1, 0);
    ew_green_to_allred_ns();              // no walk here: pending was cleared

    // 3: request on the very tick that expires NS_YELLOW
    green_ns_full();
    tk(2, 1, Y, R, 0, 1); tk(2, 0, Y, R, 0, 0);
    ped_req = 1'b1;
    tk(3, 2, R, R, 1, 1);
    ped_req = 1'b0;
    tk(3, 1, R, R, 1, 0); tk(3, 0, R, R, 1, 0);
    tk(4, 3, R, G, 0, 1);

    // 4: night requested mid EW_GREEN
    night_mode = 1'b1;
    tk(4, 2, R, G, 0, 0); tk(4, 1, R, G, 0, 0); tk(4, 0, R, G, 0, 0);
    tk(6, 0, O, O, 0, 1); tk(6, 0, Y, Y, 0, 0);
    tk(6, 0, O, O, 0, 0); tk(6, 0, Y, Y, 0, 0);
    night_mode = 1'b0;
    tk(0, 0, R, R, 0, 1);

    // 5: freeze inside NS_YELLOW
    green_ns_full();
    tk(2, 1, Y, R, 0, 1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) tk(2, 1, Y, R, 0, 0);
    en = 1'b1;
    tk(2, 0, Y, R, 0, 0);
    tk(3, 0, R, R, 0, 1);

    // 6: async reset mid EW_YELLOW with a pending request
    tk(4, 3, R, G, 0, 1); tk(4, 2, R, G, 0, 0); tk(4, 1, R, G, 0, 0);
    tk(4, 0, R, G, 0, 0); tk(5, 1, R, Y, 0, 1);
    idle(1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    full_cycle();                         // ALLRED_EW without walk proves pending cleared
    idle(1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending entries need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
